fraction_reducer: RTL and testbench
===================================

# fraction_reducer

Reduces a fraction num/den to lowest terms using the result of the GCD core. It runs beside the GCD core and consumes its output. Both blocks receive the same `start`, `a`/`num` and `b`/`den`. This block latches the operands, waits for the GCD core's single-cycle `done` pulse, and captures the GCD in that cycle. It then divides both operands by the GCD with two sequential 8-bit restoring divisions and presents the reduced pair with a one-cycle `done` pulse.

## Interface
- No parameters; all datapaths are fixed at 8 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: operand capture strobe, shared with the GCD core; sampled only in IDLE.
- `num` in 8: numerator, valid in the `start` cycle.
- `den` in 8: denominator, valid in the `start` cycle.
- `gcd_done` in 1: single-cycle done pulse from the GCD core; sampled only in WAIT_G.
- `gcd` in 8: GCD core result, valid only while `gcd_done`=1.
- `done` out 1: one-cycle pulse; `num_r`, `den_r` and `err` are valid from this cycle on.
- `num_r` out 8: num / gcd.
- `den_r` out 8: den / gcd.
- `err` out 1: gcd was 0, or either division left a nonzero remainder.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, WAIT_G, DIV_N, DIV_D, DONE.
- IDLE:
  - `start`=1 latches `num`→N and `den`→D, then goes to WAIT_G.
  - `gcd_done` is ignored.
- WAIT_G:
  - Waits indefinitely; no timeout.
  - `gcd_done`=1 latches `gcd`→G.
  - If G==0 (both operands were 0), go to DONE with results 0/0 and `err`=1.
  - Otherwise clear the remainder and quotient, load the bit counter with 7 and go to DIV_N.
  - `start` is ignored.
- DIV_N: restoring division of N by G, one quotient bit per cycle, MSB first.
  - Remainder register is 9 bits: R' = {R[7:0], N[bit]}.
  - If R' ≥ {1'b0,G}: R = R' − G and quotient bit = 1; else R = R' and quotient bit = 0.
  - After bit 0: store the quotient to a result register. A final remainder ≠ 0 sets the error latch.
  - Then reload the counter with 7, clear R and go to DIV_D.
- DIV_D: identical procedure on D; after bit 0 go to DONE.
- DONE (one cycle):
  - Drive `done`=1.
  - Update `num_r`, `den_r` and `err` from the result registers and error latch.
  - Return to IDLE.
- Outputs hold their last values until the next DONE or reset.
- `start` asserted in any non-IDLE state has no effect. Upstream must not restart the GCD core until `busy`=0.
- Arithmetic is unsigned 8-bit; no overflow is possible, since quotient ≤ dividend.

## Timing
- Reset values:
  - state = IDLE; `done`=0, `busy`=0, `num_r`=0, `den_r`=0, `err`=0.
  - All internal registers are 0.
- Reset asserted mid-operation:
  - Abort on the next edge to IDLE with the reset values above.
  - No `done` pulse is produced.
  - A `gcd_done` arriving in the same cycle as `rst` is discarded.
- Latency, counting from the edge that samples `gcd_done`=1 in WAIT_G as edge 0:
  - DIV_N in cycles 1–8, DIV_D in cycles 9–16, DONE in cycle 17.
  - Total: `done`=1 exactly 17 cycles after `gcd_done`.
- G==0 path: DONE in cycle 1, so `done` follows one cycle after `gcd_done`.
- `busy` rises the cycle after the accepted `start` and falls the cycle after `done`.
- Back-to-back operation: a new `start` is accepted in the cycle after DONE, i.e. the first IDLE cycle.

## Test plan
- Reset, then num=12, den=18 with `start`; `gcd_done`/`gcd`=6 five cycles later.
  - Expect `done` 17 cycles after `gcd_done`, num_r=2, den_r=3, err=0.
- num=255, den=1, gcd=1 → num_r=255, den_r=1, err=0. This covers the full-width dividend.
- num=0, den=0, gcd=0 → `done` one cycle after `gcd_done`, num_r=0, den_r=0, err=1.
- num=0, den=40, gcd=40 → num_r=0, den_r=1, err=0.
- num=10, den=15, with an inconsistent gcd=4:
  - num_r=2 (remainder 2), den_r=3 (remainder 3), err=1.
- Reset and ignore checks:
  - Assert `rst` for one cycle during DIV_D → next cycle IDLE, all outputs 0, no `done`.
  - `start` pulses in WAIT_G are ignored.
  - A stray `gcd_done` in IDLE is ignored.
  - An immediate second operation (7/21, gcd 7) yields 1/3.

Source files
------------

// File: rtl/fraction_reducer_if.sv
// rtl/fraction_reducer_if.sv - operand/GCD/result bundle for fraction_reducer
//
// Purpose: groups the fraction reducer's request, GCD-core and result signals.
// Signals:
//   start    - operand capture strobe (shared with the GCD core)
//   num, den - 8-bit operands, valid in the start cycle
//   gcd_done - single-cycle done pulse from the GCD core
//   gcd      - GCD core result, valid while gcd_done=1
//   done     - one-cycle result pulse
//   num_r    - num / gcd
//   den_r    - den / gcd
//   err      - gcd was 0 or a division left a remainder
//   busy     - high whenever the reducer is not idle
// Modports: master drives requests and GCD results, slave is the reducer.

interface fraction_reducer_if;
  logic       start;
  logic [7:0] num;
  logic [7:0] den;
  logic       gcd_done;
  logic [7:0] gcd;
  logic       done;
  logic [7:0] num_r;
  logic [7:0] den_r;
  logic       err;
  logic       busy;

  modport master (
    output start, num, den, gcd_done, gcd,
    input  done, num_r, den_r, err, busy
  );

  modport slave (
    input  start, num, den, gcd_done, gcd,
    output done, num_r, den_r, err, busy
  );
endinterface

// File: rtl/fraction_reducer.sv
// rtl/fraction_reducer.sv - reduces num/den to lowest terms using an external GCD
//
// Purpose: latches num/den on start, waits for the GCD core's done pulse, then
// divides both operands by the GCD with two sequential 8-bit restoring
// divisions (one quotient bit per cycle) and pulses done with the results.
// Ports:
//   clk - single clock, rising edge
//   rst - synchronous active-high reset
//   bus - fraction_reducer_if.slave (start/num/den/gcd_done/gcd in,
//         done/num_r/den_r/err/busy out)

module fraction_reducer (
  input  logic              clk,
  input  logic              rst,
  fraction_reducer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_G,
    DIV_N,
    DIV_D,
    DONE
  } state_t;

  state_t     state_q;
  logic [7:0] n_q;
  logic [7:0] d_q;
  logic [7:0] g_q;
  logic [7:0] rem_q;
  logic [7:0] quo_q;
  logic [7:0] qn_q;
  logic [2:0] cnt_q;
  logic       err_lat_q;

  logic       done_q;
  logic       busy_q;
  logic [7:0] num_r_q;
  logic [7:0] den_r_q;
  logic       err_q;

  // One restoring-division step. The shifted trial remainder needs 9 bits,
  // but the restored remainder is always < G, so only 8 bits are stored.
  logic [7:0] dividend_d;
  logic [8:0] shift_d;
  logic       ge_d;
  logic [8:0] rem_d;
  logic [7:0] quo_d;

  always_comb begin
    dividend_d = (state_q == DIV_D) ? d_q : n_q;
    shift_d    = {rem_q, dividend_d[cnt_q]};
    ge_d       = (shift_d >= {1'b0, g_q});
    rem_d      = ge_d ? (shift_d - {1'b0, g_q}) : shift_d;
    quo_d      = {quo_q[6:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= 8'd0;
      d_q       <= 8'd0;
      g_q       <= 8'd0;
      rem_q     <= 8'd0;
      quo_q     <= 8'd0;
      qn_q      <= 8'd0;
      cnt_q     <= 3'd0;
      err_lat_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      num_r_q   <= 8'd0;
      den_r_q   <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            n_q       <= bus.num;
            d_q       <= bus.den;
            err_lat_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= WAIT_G;
          end
        end

        WAIT_G: begin
          if (bus.gcd_done) begin
            g_q <= bus.gcd;
            if (bus.gcd == 8'd0) begin
              // Both operands were zero: nothing to divide.
              num_r_q <= 8'd0;
              den_r_q <= 8'd0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rem_q   <= 8'd0;
              quo_q   <= 8'd0;
              cnt_q   <= 3'd7;
              state_q <= DIV_N;
            end
          end
        end

        DIV_N: begin
          rem_q <= rem_d[7:0];
          quo_q <= quo_d;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            qn_q <= quo_d;
            if (rem_d != 9'd0) begin
              err_lat_q <= 1'b1;
            end
            rem_q   <= 8'd0;
            quo_q   <= 8'd0;
            cnt_q   <= 3'd7;
            state_q <= DIV_D;
          end
        end

        DIV_D: begin
          rem_q <= rem_d[7:0];
          quo_q <= quo_d;
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            // Results are registered on entry to DONE so they are valid
            // in the same cycle as the done pulse.
            num_r_q <= qn_q;
            den_r_q <= quo_d;
            err_q   <= err_lat_q | (rem_d != 9'd0);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.num_r = num_r_q;
  assign bus.den_r = den_r_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_fraction_reducer.sv
// tb/tb_fraction_reducer.sv - self-checking bench for fraction_reducer
//
// Purpose: drives directed and random fractions through the reducer, acting
// as the GCD core, and compares results, latency and busy/done timing with a
// plain-arithmetic reference model.

module tb_fraction_reducer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fraction_reducer_if fr_if ();

  fraction_reducer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (fr_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; gcd 0 yields 0/0 with error.
  function automatic void model(input logic [7:0] n, input logic [7:0] d,
                                input logic [7:0] g, output logic [7:0] nr,
                                output logic [7:0] dr, output logic e,
                                output int lat);
    if (g == 8'd0) begin
      nr  = 8'd0;
      dr  = 8'd0;
      e   = 1'b1;
      lat = 1;
    end else begin
      nr  = n / g;
      dr  = d / g;
      e   = ((n % g) != 0) || ((d % g) != 0);
      lat = 17;
    end
  endfunction

  function automatic logic [7:0] euclid(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Plays the upstream and GCD-core roles for one operation. Starts
  // driving immediately, so a call right after a previous one lands in
  // the first IDLE cycle. Returns observations only.
  task automatic do_op(input logic [7:0] n, input logic [7:0] d,
                       input logic [7:0] g, input int gap, input bit poke,
                       output int lat, output logic [7:0] nr,
                       output logic [7:0] dr, output logic e,
                       output logic busy_st, output logic done_after,
                       output logic busy_after);
    fr_if.start = 1'b1;
    fr_if.num   = n;
    fr_if.den   = d;
    @(posedge clk); #1;
    fr_if.start = 1'b0;
    fr_if.num   = 8'($urandom);
    fr_if.den   = 8'($urandom);
    busy_st     = fr_if.busy;
    for (int i = 0; i < gap; i++) begin
      if (poke) begin
        fr_if.start = 1'b1;
        fr_if.num   = 8'($urandom);
        fr_if.den   = 8'($urandom);
      end
      @(posedge clk); #1;
      fr_if.start = 1'b0;
    end
    fr_if.gcd_done = 1'b1;
    fr_if.gcd      = g;
    @(posedge clk); #1;
    fr_if.gcd_done = 1'b0;
    fr_if.gcd      = 8'($urandom);
    lat = 1;
    while (fr_if.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    nr = fr_if.num_r;
    dr = fr_if.den_r;
    e  = fr_if.err;
    @(posedge clk); #1;
    done_after = fr_if.done;
    busy_after = fr_if.busy;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    fr_if.start    = 1'b0;
    fr_if.num      = 8'd0;
    fr_if.den      = 8'd0;
    fr_if.gcd_done = 1'b0;
    fr_if.gcd      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({fr_if.done, fr_if.busy, fr_if.num_r, fr_if.den_r, fr_if.err} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: done=%b busy=%b num_r=%0d den_r=%0d err=%b, required all 0",
               fr_if.done, fr_if.busy, fr_if.num_r, fr_if.den_r, fr_if.err);
    end
  endtask

  task automatic test_directed();
    logic [7:0] tn [6] = '{8'd12, 8'd255, 8'd0, 8'd0,  8'd10, 8'd128};
    logic [7:0] td [6] = '{8'd18, 8'd1,   8'd0, 8'd40, 8'd15, 8'd255};
    logic [7:0] tg [6] = '{8'd6,  8'd1,   8'd0, 8'd40, 8'd4,  8'd1};
    int         gaps [6] = '{5, 0, 2, 1, 3, 0};
    for (int i = 0; i < 6; i++) begin
      int lat, elat;
      logic [7:0] nr, dr, enr, edr;
      logic e, ee, bst, dafter, bafter;
      do_op(tn[i], td[i], tg[i], gaps[i], 1'b0, lat, nr, dr, e, bst, dafter, bafter);
      model(tn[i], td[i], tg[i], enr, edr, ee, elat);
      tests++;
      if (lat !== elat) begin
        fails++;
        $display("FAIL dir%0d_latency: got %0d cycles, required %0d", i, lat, elat);
      end
      tests++;
      if ({nr, dr, e} !== {enr, edr, ee}) begin
        fails++;
        $display("FAIL dir%0d_result: got %0d/%0d err=%b, required %0d/%0d err=%b",
                 i, nr, dr, e, enr, edr, ee);
      end
      tests++;
      if ({bst, dafter, bafter} !== 3'b100) begin
        fails++;
        $display("FAIL dir%0d_handshake: busy_after_start=%b done_next=%b busy_next=%b, required 1 0 0",
                 i, bst, dafter, bafter);
      end
      tests++;
      if ({fr_if.num_r, fr_if.den_r, fr_if.err} !== {enr, edr, ee}) begin
        fails++;
        $display("FAIL dir%0d_hold: got %0d/%0d err=%b after done, required %0d/%0d err=%b",
                 i, fr_if.num_r, fr_if.den_r, fr_if.err, enr, edr, ee);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int lat, elat;
      logic [7:0] n, d, g, nr, dr, enr, edr;
      logic e, ee, bst, dafter, bafter;
      n = 8'($urandom);
      d = 8'($urandom);
      if (i % 3 == 2) g = 8'($urandom_range(1, 255));
      else            g = euclid(n, d);
      do_op(n, d, g, $urandom_range(0, 6), 1'b0, lat, nr, dr, e, bst, dafter, bafter);
      model(n, d, g, enr, edr, ee, elat);
      tests++;
      if (lat !== elat || {nr, dr, e} !== {enr, edr, ee} || {bst, dafter, bafter} !== 3'b100) begin
        fails++;
        $display("FAIL rand%0d: %0d/%0d g=%0d got %0d/%0d err=%b lat=%0d hs=%b%b%b, required %0d/%0d err=%b lat=%0d hs=100",
                 i, n, d, g, nr, dr, e, lat, bst, dafter, bafter, enr, edr, ee, elat);
      end
    end
  endtask

  task automatic test_ignore();
    int lat, elat;
    logic [7:0] nr, dr, enr, edr, hold_n, hold_d;
    logic e, ee, bst, dafter, bafter, hold_e, seen;
    hold_n = fr_if.num_r;
    hold_d = fr_if.den_r;
    hold_e = fr_if.err;
    fr_if.gcd_done = 1'b1;
    fr_if.gcd      = 8'd9;
    @(posedge clk); #1;
    fr_if.gcd_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fr_if.done !== 1'b0 || fr_if.busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 1'b0 || {fr_if.num_r, fr_if.den_r, fr_if.err} !== {hold_n, hold_d, hold_e}) begin
      fails++;
      $display("FAIL stray_gcd_done: activity=%b outputs %0d/%0d err=%b, required no activity and %0d/%0d err=%b",
               seen, fr_if.num_r, fr_if.den_r, fr_if.err, hold_n, hold_d, hold_e);
    end
    do_op(8'd30, 8'd45, 8'd15, 4, 1'b1, lat, nr, dr, e, bst, dafter, bafter);
    model(8'd30, 8'd45, 8'd15, enr, edr, ee, elat);
    tests++;
    if (lat !== elat || {nr, dr, e} !== {enr, edr, ee} || {dafter, bafter} !== 2'b00) begin
      fails++;
      $display("FAIL start_in_wait: got %0d/%0d err=%b lat=%0d, required %0d/%0d err=%b lat=%0d",
               nr, dr, e, lat, enr, edr, ee, elat);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    fr_if.start = 1'b1;
    fr_if.num   = 8'd100;
    fr_if.den   = 8'd50;
    @(posedge clk); #1;
    fr_if.start    = 1'b0;
    fr_if.gcd_done = 1'b1;
    fr_if.gcd      = 8'd50;
    @(posedge clk); #1;
    fr_if.gcd_done = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    // Now in DIV_D; reset with a coincident gcd_done that must be discarded.
    rst            = 1'b1;
    fr_if.gcd_done = 1'b1;
    fr_if.gcd      = 8'd5;
    @(posedge clk); #1;
    rst            = 1'b0;
    fr_if.gcd_done = 1'b0;
    tests++;
    if ({fr_if.done, fr_if.busy, fr_if.num_r, fr_if.den_r, fr_if.err} !== 19'd0) begin
      fails++;
      $display("FAIL reset_mid: done=%b busy=%b num_r=%0d den_r=%0d err=%b, required all 0",
               fr_if.done, fr_if.busy, fr_if.num_r, fr_if.den_r, fr_if.err);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fr_if.done !== 1'b0 || fr_if.busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_quiet: done/busy activity=%b after reset, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [7:0] nr1, dr1, nr2, dr2;
    logic e1, e2, b1, b2, da1, da2, ba1, ba2;
    do_op(8'd12, 8'd18, 8'd6, 1, 1'b0, lat1, nr1, dr1, e1, b1, da1, ba1);
    do_op(8'd7, 8'd21, 8'd7, 0, 1'b0, lat2, nr2, dr2, e2, b2, da2, ba2);
    tests++;
    if ({nr1, dr1, e1} !== {8'd2, 8'd3, 1'b0} || lat1 !== 17) begin
      fails++;
      $display("FAIL b2b_first: got %0d/%0d err=%b lat=%0d, required 2/3 err=0 lat=17",
               nr1, dr1, e1, lat1);
    end
    tests++;
    if ({nr2, dr2, e2} !== {8'd1, 8'd3, 1'b0} || lat2 !== 17 || b2 !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: got %0d/%0d err=%b lat=%0d busy=%b, required 1/3 err=0 lat=17 busy=1",
               nr2, dr2, e2, lat2, b2);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
